// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: SHA-256 constants, round helpers and miner state encoding.
package bitcoin_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_BLOCK1,
        S_BLOCK2,
        S_HASH2,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV_STATE = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Working state is packed a..h from the MSB down.
    function automatic logic [255:0] sha256_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + Sigma1(e) + ch(e, f, g) + k + w;
        t2 = Sigma0(a) + maj(a, b, c);
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

endpackage

// File: rtl/sha256_compress.sv
// sha256_compress: iterative one-round-per-cycle SHA-256 compression; digest is valid
// for the single cycle valid is high, and a new load may be issued in that same cycle.
module sha256_compress
    import bitcoin_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [255:0] chain_in,
    input  logic [511:0] block_in,
    output logic [255:0] digest,
    output logic         valid
);

    logic [255:0] st;
    logic [255:0] chain;
    logic [31:0]  w [0:15];
    logic [5:0]   round;
    logic         busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st    <= '0;
            chain <= '0;
            round <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            valid <= busy && round == 6'd63;
            if (load) begin
                st    <= chain_in;
                chain <= chain_in;
                round <= '0;
                busy  <= 1'b1;
                for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
            end else if (busy) begin
                st    <= sha256_round(st, K[round], w[0]);
                // w[0] is always w[t]; the window slides and appends w[t+16].
                for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
                round <= round + 6'd1;
                busy  <= round != 6'd63;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_add
        assign digest[255 - 32*g -: 32] = chain[255 - 32*g -: 32] + st[255 - 32*g -: 32];
    end

endmodule

// File: rtl/bitcoin1_miner.sv
// bitcoin1_miner: double-SHA-256 nonce sweep over a 19-word header in shared SRAM,
// writing H0 of each final digest to output_addr+nonce.
module bitcoin1_miner
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t       state, state_n;
    logic [15:0]  out_a;
    logic [4:0]   cnt;
    logic [31:0]  nonce;
    logic [31:0]  hdr [0:18];
    logic [255:0] mid;
    logic         load;
    logic         valid;
    logic         last;
    logic [255:0] chain_in;
    logic [255:0] digest;
    logic [511:0] block_in;
    logic [511:0] blk1;
    logic [511:0] blk2;
    logic [31:0]  nonce_sel;

    assign mem_clk   = clk;
    assign last      = nonce == 32'(NUM_NONCES - 1);
    assign nonce_sel = state == S_WRITE ? nonce + 32'd1 : 32'd0;
    assign blk2      = {hdr[16], hdr[17], hdr[18], nonce_sel, 32'h80000000, 320'd0, 32'd640};

    always_comb begin
        blk1 = '0;
        for (int i = 0; i < 16; i++) blk1[511 - 32*i -: 32] = hdr[i];
    end

    sha256_compress u_compress (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .chain_in(chain_in),
        .block_in(block_in),
        .digest  (digest),
        .valid   (valid)
    );

    always_ff @(posedge clk or negedge reset_n)
        state <= !reset_n ? S_IDLE : state_n;

    // Each compression is launched in the cycle its predecessor's digest is valid.
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        chain_in = IV_STATE;
        block_in = blk1;
        case (state)
            S_IDLE:   state_n = start ? S_READ : S_IDLE;
            S_READ: begin
                load    = cnt == 5'd19;
                state_n = load ? S_BLOCK1 : S_READ;
            end
            S_BLOCK1: begin
                load     = valid;
                chain_in = digest;
                block_in = blk2;
                state_n  = valid ? S_BLOCK2 : S_BLOCK1;
            end
            S_BLOCK2: begin
                load     = valid;
                block_in = {digest, 32'h80000000, 192'd0, 32'd256};
                state_n  = valid ? S_HASH2 : S_BLOCK2;
            end
            S_HASH2:  state_n = valid ? S_WRITE : S_HASH2;
            S_WRITE: begin
                load     = !last;
                chain_in = mid;
                block_in = blk2;
                state_n  = last ? S_DONE : S_BLOCK2;
            end
            S_DONE:   state_n = start ? S_DONE : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            out_a          <= '0;
            cnt            <= '0;
            nonce          <= '0;
            mid            <= '0;
            for (int i = 0; i < 19; i++) hdr[i] <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    out_a    <= output_addr;
                    mem_addr <= message_addr;
                    done     <= 1'b0;
                    cnt      <= '0;
                    nonce    <= '0;
                end
                S_READ: begin
                    // Read data lags its address by one cycle, so word cnt-1 is on the bus now.
                    cnt <= cnt + 5'd1;
                    if (cnt != 5'd0) hdr[cnt - 5'd1] <= mem_read_data;
                    if (cnt < 5'd18) mem_addr <= mem_addr + 16'd1;
                end
                S_BLOCK1: if (valid) mid <= digest;
                S_HASH2: if (valid) begin
                    mem_we         <= 1'b1;
                    mem_addr       <= out_a + nonce[15:0];
                    mem_write_data <= digest[255:224];
                end
                S_WRITE: begin
                    if (last) done <= 1'b1;
                    else nonce <= nonce + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin1_miner.sv
// tb_bitcoin1_miner: table-driven checks of the nonce sweep against a behavioural double-SHA model.
module tb_bitcoin1_miner;

    localparam logic [31:0] MK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IVB = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam int MAX_LAT = 20 + 65 + 16 * (2 * 65 + 2);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] message_addr = '0;
    logic [15:0] output_addr = '0;
    logic        done, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, mem_read_data;

    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [31:0] tb_data = '0;
    logic [31:0] mem [0:65535];

    int checks = 0;
    int fails = 0;

    bit          mon = 1'b0;
    bit          seen_wr;
    int          nwr;
    int          bad_rd;
    logic [15:0] wr_addr [0:63];
    logic [18:0] rd_seen;
    logic [15:0] mon_msg;
    logic [15:0] rd_off;

    typedef struct {
        logic [31:0]  seed;
        logic [15:0]  msg;
        logic [15:0]  outa;
        int           hold;
        int           nwr;
        logic [511:0] exp_r;
    } vec_t;
    vec_t vt [0:5];

    always #5 clk = ~clk;

    bitcoin1_miner #(.NUM_NONCES(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .message_addr  (message_addr),
        .output_addr   (output_addr),
        .done          (done),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    // SRAM: the bench port preloads headers only while the DUT is idle.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        if (mem_we) mem[mem_addr] <= mem_write_data;
        else mem_read_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mon) begin
            if (mem_we) begin
                if (nwr < 64) wr_addr[nwr] = mem_addr;
                nwr++;
                seen_wr = 1'b1;
            end else if (!seen_wr) begin
                rd_off = mem_addr - mon_msg;
                if (rd_off < 16'd19) rd_seen[rd_off] = 1'b1;
                else bad_rd++;
            end
        end
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] m_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] v [0:7];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + MK[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [31:0] hdr_word(input logic [31:0] seed, input int m);
        logic [31:0] x = seed;
        for (int i = 0; i < m; i++) x = {x[30:0], x[31]};
        return x;
    endfunction

    function automatic logic [31:0] ref_h0(input logic [31:0] seed, input logic [31:0] n);
        logic [511:0] b;
        logic [255:0] md, d, r;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = hdr_word(seed, i);
        md = m_comp(IVB, b);
        d  = m_comp(md, {hdr_word(seed, 16), hdr_word(seed, 17), hdr_word(seed, 18), n, 32'h80000000, 320'd0, 32'h280});
        r  = m_comp(IVB, {d, 32'h80000000, 192'd0, 32'h100});
        return r[255:224];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_hdr(input int v);
        for (int i = 0; i < 19; i++) begin
            tb_we   = 1'b1;
            tb_addr = vt[v].msg + 16'(i);
            tb_data = hdr_word(vt[v].seed, i);
            @(negedge clk);
        end
        tb_we = 1'b0;
    endtask

    task automatic kick(input int v);
        message_addr = vt[v].msg;
        output_addr  = vt[v].outa;
        nwr = 0; seen_wr = 1'b0; rd_seen = '0; bad_rd = 0; mon_msg = vt[v].msg;
        start = 1'b1;
        @(posedge clk);
        #1;
        mon = 1'b1;
        check("done_drop", {31'd0, done}, 32'd0);
    endtask

    task automatic run_vec(input int v, input bit done_before);
        int cyc = 0;
        load_hdr(v);
        if (done_before) check("done_held_idle", {31'd0, done}, 32'd1);
        kick(v);
        while (cyc < MAX_LAT + 200) begin
            @(negedge clk);
            cyc++;
            if (cyc >= vt[v].hold) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        check("done_set", {31'd0, done}, 32'd1);
        check("latency", cyc <= MAX_LAT ? 32'd0 : 32'(cyc), 32'd0);
        check("we_at_done", {31'd0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        mon = 1'b0;
        check("write_count", 32'(nwr), 32'(vt[v].nwr));
        for (int i = 0; i < 16 && i < nwr; i++)
            check($sformatf("wr_addr[%0d]", i), {16'd0, wr_addr[i]}, {16'd0, vt[v].outa + 16'(i)});
        for (int i = 0; i < 16; i++)
            check($sformatf("h0[v%0d n%0d]", v, i), mem[vt[v].outa + 16'(i)], vt[v].exp_r[511 - 32*i -: 32]);
        check("reads_cover", {13'd0, rd_seen}, {13'd0, 19'h7FFFF});
        check("reads_outside", 32'(bad_rd), 32'd0);
        for (int i = 0; i < 19; i++)
            check($sformatf("hdr_kept[%0d]", i), mem[vt[v].msg + 16'(i)], hdr_word(vt[v].seed, i));
        repeat (3) @(negedge clk);
        check("done_in_idle", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [255:0] abc;
        vt[0] = '{32'h01234567, 16'd0,      16'd1000,   2,  16, '0};
        vt[1] = '{32'hDEADBEEF, 16'h0100,   16'h2000,   1,  16, '0};
        vt[2] = '{32'h0F1E2D3C, 16'hFFF0,   16'h0005,   3,  16, '0};
        vt[3] = '{32'h55AA00FF, 16'h3000,   16'hFFF8,   10, 16, '0};
        vt[4] = '{32'h89ABCDEF, 16'd0,      16'd1000,   10, 16, '0};
        vt[5] = '{32'h13579BDF, 16'h0400,   16'h0500,   2,  16, '0};
        for (int v = 0; v < 6; v++)
            for (int n = 0; n < 16; n++) vt[v].exp_r[511 - 32*n -: 32] = ref_h0(vt[v].seed, 32'(n));

        abc = m_comp(IVB, {32'h61626380, 448'd0, 32'h18});
        check("model_abc", abc[255:224], 32'hba7816bf);

        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(v, v > 0);

        load_hdr(5);
        kick(5);
        for (int c = 1; c < 120; c++) begin
            @(negedge clk);
            if (c >= vt[5].hold) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_writes", 32'(nwr), 32'd0);
        check("abort_idle_done", {31'd0, done}, 32'd0);
        mon = 1'b0;
        run_vec(5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bitcoin1_miner.md
Name: bitcoin1_miner

Overview:
- Bitcoin-style double-SHA-256 nonce sweep co-processor.
- Reads a 19-word (608-bit) block header from shared single-port SRAM and computes the first-block midstate once.
- For each nonce 0..NUM_NONCES-1, computes SHA256(SHA256(header‖nonce)) and writes word H0 of the final digest back to SRAM.
- Sits as a memory-mapped accelerator next to a processor that owns the SRAM.

Parameters:
- NUM_NONCES, 16, number of nonces swept (0..NUM_NONCES-1); one output word per nonce.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  level request; sampled only in IDLE.
- message_addr  in  16  word address of header word 0.
- output_addr  in  16  word address of result for nonce 0.
- done  out  1  high when all results are written.
- mem_clk  out  1  SRAM clock; driven as clk.
- mem_we  out  1  1 = write mem_write_data to mem_addr at mem_clk rise; 0 = read.
- mem_addr  out  16  SRAM word address.
- mem_write_data  out  32  SRAM write data.
- mem_read_data  in  32  SRAM read data; updated at the mem_clk rise that samples a read address.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; done=0, mem_we=0, mem_addr=0, mem_write_data=0.
  - All hash registers cleared.
- IDLE:
  - start=1 -> latch message_addr/output_addr, clear done, go READ.
  - start may stay high several cycles; only one run is launched per IDLE->READ transition.
- READ:
  - Issue reads of message_addr+0..+18, one address per cycle, mem_we=0.
  - Data for address issued at edge k is valid on mem_read_data after edge k and is captured at edge k+1 (one-cycle latency, pipelined).
  - Store the 19 words in a header register array.
- BLOCK1:
  - Message words = header[0..15]; chaining in = SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - 64 rounds, one round per cycle.
  - Message schedule: rolling 16-word window; w[t] = w[t-16] + σ0(w[t-15]) + w[t-7] + σ1(w[t-2]).
    - σ0 = ror7^ror18^shr3; σ1 = ror17^ror19^shr10.
  - Round: T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+w[t]; T2 = Σ0(a)+Maj(a,b,c).
    - Σ1 = ror6^ror11^ror25; Σ0 = ror2^ror13^ror22.
  - Midstate = IV + final a..h (word-wise, mod 2^32). Computed once per run.
- Per nonce n (0..NUM_NONCES-1), loop BLOCK2 -> HASH2 -> WRITE:
  - BLOCK2:
    - Words = header[16], header[17], header[18], n, 0x80000000, 0 ×10, 0x00000280 (640).
    - Chaining in = midstate; digest D = midstate + final a..h.
  - HASH2:
    - Words = D0..D7, 0x80000000, 0 ×6, 0x00000100 (256).
    - Chaining in = IV; result R = IV + final a..h.
  - WRITE: one cycle with mem_we=1, mem_addr=output_addr+n, mem_write_data=R0.
- All arithmetic is 32-bit modulo 2^32; addresses are 16-bit and wrap at 0xFFFF.
- DONE:
  - After the write for n=NUM_NONCES-1, done=1 and mem_we=0.
  - Stay in DONE until start=0, then go IDLE. done remains 1 in IDLE until the next start.
- mem_we is 1 only in WRITE cycles; the block never writes outside output_addr..output_addr+NUM_NONCES-1.
- Reset asserted mid-run aborts immediately to IDLE with no further writes.
- Latency target: ≤ 20 + 65 + NUM_NONCES·(2·65+2) cycles from start.

Decomposition:
- Package bitcoin_pkg holds:
  - K[0:63] round constants;
  - IV[0:7];
  - functions rightrotate, sigma0, sigma1, Sigma0, Sigma1, ch, maj, sha256_round;
  - state-enum typedef.
- One sub-module, sha256_compress: load (chaining in, 16 words), 64-cycle iterative compression, outputs 256-bit digest plus a valid pulse.
- Reused sequentially for BLOCK1, BLOCK2 and HASH2.

Test Plan:
- Reset, then header seed: word0=0x01234567, word[m] = rotl1(word[m-1]); message_addr=0, output_addr=1000, start high 2 cycles -> done=1 eventually. mem[1000..1015] equal H0 from a behavioural double-SHA model with nonce 0..15 in header word 19 and padding 0x80000000, 640.
- Same run: monitor mem_we -> exactly 16 writes, addresses 1000..1015 in ascending order; no write below 1000 or above 1015; reads only cover 0..18.
- message_addr=0x0100, output_addr=0x2000, seed 0xDEADBEEF -> results at 0x2000..0x200F match the model; header words at 0x0100..0x0112 are unchanged.
- Assert reset_n=0 for 1 cycle mid-BLOCK2 -> done=0, mem_we=0 at once; a subsequent start gives correct results.
- Second start after done, with a different seed -> done drops, new results overwrite the old ones and are correct.
- start held high 10 cycles -> a single run; exactly 16 writes.
